char_plotter: RTL and testbench



---
 rtl/vga_pkg.sv | 18 +
 rtl/char_plotter.sv | 172 +++++++++++++++++
 tb/tb_char_plotter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and the glyph plotter state encoding.
package vga_pkg;

  localparam int unsigned DEF_H_RES   = 160;
  localparam int unsigned DEF_V_RES   = 120;
  localparam int unsigned DEF_X_W     = 8;
  localparam int unsigned DEF_Y_W     = 7;
  localparam int unsigned DEF_COLOR_W = 3;
  localparam int unsigned GLYPH_SZ    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/char_plotter.sv
// Renders one 8x8 glyph from an external combinational ROM as a stream of
// registered pixel writes, clipped against the framebuffer bounds.
module char_plotter
  import vga_pkg::*;
#(
  parameter int unsigned H_RES   = DEF_H_RES,
  parameter int unsigned V_RES   = DEF_V_RES,
  parameter int unsigned X_W     = DEF_X_W,
  parameter int unsigned Y_W     = DEF_Y_W,
  parameter int unsigned COLOR_W = DEF_COLOR_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [7:0]         char_code,
  input  logic [X_W-1:0]     x_origin,
  input  logic [Y_W-1:0]     y_origin,
  input  logic [COLOR_W-1:0] fg_colour,
  input  logic [COLOR_W-1:0] bg_colour,
  input  logic               transparent,
  output logic [7:0]         glyph_code,
  input  logic [63:0]        glyph_bits,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               plot
);

  localparam int unsigned NPIX  = GLYPH_SZ * GLYPH_SZ;
  localparam int unsigned IDX_W = $clog2(NPIX);
  localparam logic [X_W:0]   X_LIM    = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0]   Y_LIM    = (Y_W + 1)'(V_RES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPIX - 1);

  state_t             state_q, state_d;
  logic [7:0]         code_q, code_d;
  logic [X_W-1:0]     xo_q, xo_d;
  logic [Y_W-1:0]     yo_q, yo_d;
  logic [COLOR_W-1:0] fg_q, fg_d, bg_q, bg_d;
  logic               tr_q, tr_d;
  logic [63:0]        glyph_q, glyph_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [X_W-1:0]     vx_q, vx_d;
  logic [Y_W-1:0]     vy_q, vy_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic               plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // Pixel about to be registered: pixel 0 straight from the ROM during LOAD,
  // otherwise the successor of the pixel currently on the outputs.
  logic [63:0]      src;
  logic [IDX_W-1:0] nidx;
  logic             pix_bit;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;
  logic             in_bounds;

  always_comb begin
    src   = (state_q == LOAD) ? glyph_bits : glyph_q;
    nidx  = (state_q == LOAD) ? '0 : IDX_W'(idx_q + 1'b1);
    // Scan index n maps to glyph bit 63-n, which is the bitwise complement.
    pix_bit   = src[~nidx];
    sum_x     = (X_W + 1)'(xo_q) + (X_W + 1)'(nidx[2:0]);
    sum_y     = (Y_W + 1)'(yo_q) + (Y_W + 1)'(nidx[5:3]);
    in_bounds = (sum_x < X_LIM) && (sum_y < Y_LIM);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      code_q  <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      tr_q    <= 1'b0;
      glyph_q <= '0;
      idx_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      tr_q    <= tr_d;
      glyph_q <= glyph_d;
      idx_q   <= idx_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    tr_d    = tr_q;
    glyph_d = glyph_q;
    idx_d   = idx_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          code_d  = char_code;
          xo_d    = x_origin;
          yo_d    = y_origin;
          fg_d    = fg_colour;
          bg_d    = bg_colour;
          tr_d    = transparent;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        state_d = DRAW;
        glyph_d = glyph_bits;
        idx_d   = '0;
        vx_d    = sum_x[X_W-1:0];
        vy_d    = sum_y[Y_W-1:0];
        col_d   = pix_bit ? fg_q : bg_q;
        plot_d  = in_bounds && (pix_bit || !tr_q);
      end
      DRAW: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = nidx;
          vx_d    = sum_x[X_W-1:0];
          vy_d    = sum_y[Y_W-1:0];
          col_d   = pix_bit ? fg_q : bg_q;
          plot_d  = in_bounds && (pix_bit || !tr_q);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign glyph_code = code_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = col_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_char_plotter.sv
// Self-checking bench for char_plotter with a behavioural glyph ROM.
module tb_char_plotter;

  localparam int H = 160;
  localparam int V = 120;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  char_code = '0;
  logic [7:0]  x_origin = '0;
  logic [6:0]  y_origin = '0;
  logic [2:0]  fg_colour = '0;
  logic [2:0]  bg_colour = '0;
  logic        transparent = 1'b0;
  logic [7:0]  glyph_code;
  logic [63:0] glyph_bits;
  logic        busy, done, plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  logic [63:0] rom [256];
  assign glyph_bits = rom[glyph_code];

  always #5 clock = ~clock;

  char_plotter dut (
    .clock(clock), .resetn(resetn), .start(start), .char_code(char_code),
    .x_origin(x_origin), .y_origin(y_origin), .fg_colour(fg_colour),
    .bg_colour(bg_colour), .transparent(transparent), .glyph_code(glyph_code),
    .glyph_bits(glyph_bits), .busy(busy), .done(done), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
  );

  typedef struct {
    logic [7:0]  code;
    logic [7:0]  xo;
    logic [6:0]  yo;
    logic [2:0]  fg;
    logic [2:0]  bg;
    logic        tr;
    logic [63:0] g;
    int          exp_plots;   // -1: no fixed expectation
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {busy, done, plot, x, y, colour} for scan position n.
  function automatic logic [20:0] model_pix(input vec_t v, input int n);
    int dx, dy, xs, ys;
    logic b, p;
    logic [2:0] c;
    dx = n % 8;
    dy = n / 8;
    xs = int'(v.xo) + dx;
    ys = int'(v.yo) + dy;
    b  = v.g[8 * (7 - dy) + (7 - dx)];
    c  = b ? v.fg : v.bg;
    p  = (xs < H) && (ys < V) && (b || !v.tr);
    return {1'b1, 1'b0, p, 8'(xs), 7'(ys), c};
  endfunction

  // Runs one draw; optionally keeps start high throughout to test re-arm.
  task automatic run_job(input vec_t v, input bit hold);
    int plots = 0;
    rom[v.code] = v.g;
    @(negedge clock);
    start = 1'b1;
    char_code = v.code; x_origin = v.xo; y_origin = v.yo;
    fg_colour = v.fg; bg_colour = v.bg; transparent = v.tr;
    @(negedge clock);
    if (!hold) start = 1'b0;
    chk("load_state", {busy, done, plot, glyph_code}, {1'b1, 1'b0, 1'b0, v.code});
    for (int i = 0; i < 64; i++) begin
      // Scramble the live inputs; the plotter must use its latched copies.
      char_code = 8'($urandom); x_origin = 8'($urandom); y_origin = 7'($urandom);
      fg_colour = 3'($urandom); bg_colour = 3'($urandom); transparent = 1'($urandom);
      if (!hold) start = (i == 29);
      @(negedge clock);
      chk($sformatf("pixel[%0d]", i),
          64'({busy, done, plot, vga_x, vga_y, vga_colour}), 64'(model_pix(v, i)));
      chk($sformatf("code_hold[%0d]", i), glyph_code, v.code);
      if (plot) plots++;
    end
    if (!hold) start = 1'b0;
    @(negedge clock);
    chk("done_cycle", {busy, done, plot}, 3'b110);
    @(negedge clock);
    chk("idle_after_done", {busy, done, plot}, 3'b000);
    if (v.exp_plots >= 0) chk("plot_count", 64'(plots), 64'(v.exp_plots));
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {$urandom, $urandom};

    vecs[0] = '{8'h41, 8'd10, 7'd20, 3'd7, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64};
    vecs[1] = '{8'h42, 8'd0, 7'd0, 3'd5, 3'd2, 1'b1, 64'h8000_0000_0000_0001, 2};
    vecs[2] = '{8'h43, 8'd40, 7'd50, 3'd6, 3'd1, 1'b0, 64'h0, 64};
    vecs[3] = '{8'h44, 8'd156, 7'd116, 3'd4, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 16};
    vecs[4] = '{8'h45, 8'd252, 7'd124, 3'd2, 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0};

    #12;
    chk("reset_outputs", {glyph_code, vga_x, vga_y, vga_colour, plot, busy, done}, '0);
    @(negedge clock);
    resetn = 1'b1;

    for (int k = 0; k < 5; k++) run_job(vecs[k], 1'b0);

    for (int k = 0; k < 12; k++) begin
      rv = '{8'($urandom), 8'($urandom), 7'($urandom), 3'($urandom), 3'($urandom),
             1'($urandom), {$urandom, $urandom}, -1};
      run_job(rv, 1'b0);
    end

    // Start held high: the plotter re-arms in the IDLE cycle after DONE.
    rv = '{8'h10, 8'd3, 7'd4, 3'd7, 3'd1, 1'b0, {$urandom, $urandom}, -1};
    run_job(rv, 1'b1);
    @(negedge clock);
    chk("rearm_busy", {busy, done, glyph_code}, {1'b1, 1'b0, char_code});
    start = 1'b0;
    begin
      int waited = 0;
      while (!done && waited < 100) begin
        @(negedge clock);
        waited++;
      end
      chk("rearm_done_seen", 64'(done), 64'(1));
      chk("rearm_draw_len", 64'(waited), 64'(65));
    end
    @(negedge clock);

    // Reset in the middle of a draw aborts immediately with no done pulse.
    rv = '{8'h20, 8'd30, 7'd30, 3'd7, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, -1};
    rom[rv.code] = rv.g;
    start = 1'b1; char_code = rv.code; x_origin = rv.xo; y_origin = rv.yo;
    fg_colour = rv.fg; bg_colour = rv.bg; transparent = rv.tr;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    chk("pre_reset_plot", {busy, plot}, 2'b11);
    #2 resetn = 1'b0;
    #1 chk("async_reset", {plot, busy, done, glyph_code}, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("reset_hold[%0d]", i), {plot, busy, done}, 3'b000);
    end
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("no_done_after_abort", {busy, done}, 2'b00);
    end
    run_job(vecs[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
